// File: rtl/mem_access_stage_if.sv
// Data-memory port bundle for the MEM stage.
//   req    request valid (master -> slave)
//   we     1 = write
//   addr   word-aligned byte address
//   be     byte enables
//   wdata  lane-shifted store data
//   gnt    request accepted this cycle (slave -> master)
//   rvalid read data valid
//   rdata  read word
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns EX/MEM outputs into a req/gnt/rvalid data-memory access,
// stalls the pipe while the access is outstanding and registers the MEM/WB outputs.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   *_mem                 EX/MEM inputs (address/ALU result, store data, rd, op controls)
//   dmem                  data-memory master port (req/we/addr/be/wdata, gnt/rvalid/rdata)
//   mem_stall             hold IF..EX/MEM while an access is in flight
//   *_wb                  registered MEM/WB outputs; mem_err_wb is a 1-cycle error pulse
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         alu_result_mem,
  input  logic [31:0]         rs2_data_mem,
  input  logic [4:0]          rd_mem,
  input  logic                mem_read_mem,
  input  logic                mem_write_mem,
  input  logic [2:0]          mem_load_type_mem,
  input  logic [1:0]          mem_store_type_mem,
  input  logic                wb_reg_file_mem,
  input  logic                memtoreg_mem,
  mem_access_stage_if.master  dmem,
  output logic                mem_stall,
  output logic [31:0]         alu_result_wb,
  output logic [31:0]         load_data_wb,
  output logic [4:0]          rd_wb,
  output logic                wb_reg_file_wb,
  output logic                memtoreg_wb,
  output logic                mem_err_wb
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic        mem_op;
  logic [1:0]  size;        // 00 byte, 01 half, else word
  logic        misaligned;
  logic        timeout;
  logic        complete;
  logic        err;
  logic        req_raw;
  logic        load_valid;
  logic [31:0] rdata_shifted;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Access decode: size, alignment, lanes
  always_comb begin
    mem_op = mem_read_mem | mem_write_mem;
    size   = mem_write_mem ? mem_store_type_mem : mem_load_type_mem[1:0];

    unique case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = alu_result_mem[0];
      default: misaligned = (alu_result_mem[1:0] != 2'b00);
    endcase
    misaligned = misaligned & mem_op;

    unique case (size)
      2'b00:   dmem.be = 4'b0001 << alu_result_mem[1:0];
      2'b01:   dmem.be = 4'b0011 << alu_result_mem[1:0];
      default: dmem.be = 4'b1111;
    endcase

    // Replicate the store value across all lanes; be picks the live ones.
    unique case (mem_store_type_mem)
      2'b00:   dmem.wdata = {4{rs2_data_mem[7:0]}};
      2'b01:   dmem.wdata = {2{rs2_data_mem[15:0]}};
      default: dmem.wdata = rs2_data_mem;
    endcase

    dmem.addr = {alu_result_mem[31:2], 2'b00};
    dmem.we   = mem_write_mem;
  end

  // Load extract: bit 2 of the load type selects zero-extension
  always_comb begin
    rdata_shifted = dmem.rdata >> {alu_result_mem[1:0], 3'b000};
    half_sel      = alu_result_mem[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    unique case (mem_load_type_mem[1:0])
      2'b00:   load_ext = {{24{~mem_load_type_mem[2] & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = {{16{~mem_load_type_mem[2] & half_sel[15]}}, half_sel};
      default: load_ext = dmem.rdata;
    endcase
  end

  // FSM next state and completion decode
  always_comb begin
    state_d    = state_q;
    complete   = 1'b0;
    err        = 1'b0;
    req_raw    = 1'b0;
    load_valid = 1'b0;
    timeout    = (cnt_q == CntW'(TIMEOUT - 1));

    unique case (state_q)
      StIdle: begin
        if (!mem_op) begin
          complete = 1'b1;
        end else if (misaligned) begin
          complete = 1'b1;
          err      = 1'b1;
        end else begin
          req_raw = 1'b1;
          // A same-cycle rvalid is ignored here: WAIT needs its own.
          if (dmem.gnt) begin
            if (mem_write_mem) complete = 1'b1;
            else               state_d  = StWait;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        req_raw = 1'b1;
        if (dmem.gnt) begin
          if (mem_write_mem) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          complete = 1'b1;
          err      = 1'b1;
          state_d  = StIdle;
        end
      end
      StWait: begin
        if (dmem.rvalid) begin
          complete   = 1'b1;
          load_valid = 1'b1;
          state_d    = StIdle;
        end else if (timeout) begin
          complete = 1'b1;
          err      = 1'b1;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Counter runs across REQ and WAIT, cleared whenever IDLE is involved.
    if (state_q != StIdle && state_d != StIdle) cnt_d = cnt_q + 1'b1;
    else                                        cnt_d = '0;
  end

  // Gated by reset so an asserted reset drops the request even while inputs hold an op.
  assign dmem.req  = req_raw & rst_n;
  assign mem_stall = ~complete & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      alu_result_wb  <= '0;
      load_data_wb   <= '0;
      rd_wb          <= '0;
      wb_reg_file_wb <= 1'b0;
      memtoreg_wb    <= 1'b0;
      mem_err_wb     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_result_wb <= alu_result_mem;
      rd_wb         <= rd_mem;
      if (complete) begin
        load_data_wb   <= load_valid ? load_ext : 32'h0;
        wb_reg_file_wb <= wb_reg_file_mem & ~err;
        memtoreg_wb    <= memtoreg_mem;
        mem_err_wb     <= err;
      end else begin
        // Bubble while the access is still outstanding
        load_data_wb   <= 32'h0;
        wb_reg_file_wb <= 1'b0;
        memtoreg_wb    <= 1'b0;
        mem_err_wb     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int unsigned Timeout = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_result_mem;
  logic [31:0] rs2_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        wb_reg_file_mem;
  logic        memtoreg_mem;
  logic        mem_stall;
  logic [31:0] alu_result_wb;
  logic [31:0] load_data_wb;
  logic [4:0]  rd_wb;
  logic        wb_reg_file_wb;
  logic        memtoreg_wb;
  logic        mem_err_wb;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TIMEOUT(Timeout)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .alu_result_mem     (alu_result_mem),
    .rs2_data_mem       (rs2_data_mem),
    .rd_mem             (rd_mem),
    .mem_read_mem       (mem_read_mem),
    .mem_write_mem      (mem_write_mem),
    .mem_load_type_mem  (mem_load_type_mem),
    .mem_store_type_mem (mem_store_type_mem),
    .wb_reg_file_mem    (wb_reg_file_mem),
    .memtoreg_mem       (memtoreg_mem),
    .dmem               (dmem.master),
    .mem_stall          (mem_stall),
    .alu_result_wb      (alu_result_wb),
    .load_data_wb       (load_data_wb),
    .rd_wb              (rd_wb),
    .wb_reg_file_wb     (wb_reg_file_wb),
    .memtoreg_wb        (memtoreg_wb),
    .mem_err_wb         (mem_err_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mem_read_mem       = 1'b0;
    mem_write_mem      = 1'b0;
    mem_load_type_mem  = 3'b000;
    mem_store_type_mem = 2'b00;
    wb_reg_file_mem    = 1'b0;
    memtoreg_mem       = 1'b0;
    dmem.gnt           = 1'b0;
    dmem.rvalid        = 1'b0;
    dmem.rdata         = 32'h0;
  endtask

  // Single load at addr with gnt in the request cycle and rvalid the next cycle.
  task automatic quick_load(input logic [2:0] ltype, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp, input string tag);
    mem_read_mem      = 1'b1;
    mem_load_type_mem = ltype;
    alu_result_mem    = addr;
    rd_mem            = 5'd7;
    wb_reg_file_mem   = 1'b1;
    memtoreg_mem      = 1'b1;
    dmem.gnt          = 1'b1;
    #1;
    chk({tag, "_req_c0"}, {31'h0, dmem.req}, 32'd1);
    chk({tag, "_stall_c0"}, {31'h0, mem_stall}, 32'd1);
    tick();
    dmem.gnt    = 1'b0;
    dmem.rvalid = 1'b1;
    dmem.rdata  = rdata;
    #1;
    chk({tag, "_req_c1"}, {31'h0, dmem.req}, 32'd0);
    chk({tag, "_stall_c1"}, {31'h0, mem_stall}, 32'd0);
    chk({tag, "_bubble_wb"}, {31'h0, wb_reg_file_wb}, 32'd0);
    tick();
    chk({tag, "_data"}, load_data_wb, exp);
    chk({tag, "_wb"}, {31'h0, wb_reg_file_wb}, 32'd1);
    chk({tag, "_rd"}, {27'h0, rd_wb}, 32'd7);
    chk({tag, "_memtoreg"}, {31'h0, memtoreg_wb}, 32'd1);
    set_idle();
  endtask

  initial begin
    rst_n          = 1'b0;
    alu_result_mem = 32'h0;
    rs2_data_mem   = 32'h0;
    rd_mem         = 5'd0;
    set_idle();
    #2;
    chk("rst_req", {31'h0, dmem.req}, 32'd0);
    chk("rst_stall", {31'h0, mem_stall}, 32'd0);
    chk("rst_alu_wb", alu_result_wb, 32'h0);
    chk("rst_wb", {31'h0, wb_reg_file_wb}, 32'd0);
    chk("rst_err", {31'h0, mem_err_wb}, 32'd0);
    #8;
    rst_n = 1'b1;
    tick();

    // ALU op passes through in one cycle
    alu_result_mem  = 32'h0000_1234;
    rd_mem          = 5'd5;
    wb_reg_file_mem = 1'b1;
    #1;
    chk("alu_stall", {31'h0, mem_stall}, 32'd0);
    chk("alu_req", {31'h0, dmem.req}, 32'd0);
    tick();
    chk("alu_rd_wb", {27'h0, rd_wb}, 32'd5);
    chk("alu_wb", {31'h0, wb_reg_file_wb}, 32'd1);
    chk("alu_res_wb", alu_result_wb, 32'h0000_1234);
    set_idle();

    // SB at 0x103, granted immediately
    mem_write_mem      = 1'b1;
    mem_store_type_mem = 2'b00;
    alu_result_mem     = 32'h0000_0103;
    rs2_data_mem       = 32'h1234_56AB;
    dmem.gnt           = 1'b1;
    #1;
    chk("sb_req", {31'h0, dmem.req}, 32'd1);
    chk("sb_we", {31'h0, dmem.we}, 32'd1);
    chk("sb_be", {28'h0, dmem.be}, 32'b1000);
    chk("sb_wdata", dmem.wdata, 32'hABAB_ABAB);
    chk("sb_addr", dmem.addr, 32'h0000_0100);
    chk("sb_stall", {31'h0, mem_stall}, 32'd0);
    tick();
    chk("sb_err", {31'h0, mem_err_wb}, 32'd0);
    set_idle();

    // SH at 0x102
    mem_write_mem      = 1'b1;
    mem_store_type_mem = 2'b01;
    alu_result_mem     = 32'h0000_0102;
    rs2_data_mem       = 32'h0000_BEEF;
    dmem.gnt           = 1'b1;
    #1;
    chk("sh_be", {28'h0, dmem.be}, 32'b1100);
    chk("sh_wdata", dmem.wdata, 32'hBEEF_BEEF);
    tick();
    set_idle();

    quick_load(3'b000, 32'h0000_0102, 32'h0080_0000, 32'hFFFF_FF80, "lb");
    quick_load(3'b100, 32'h0000_0102, 32'h0080_0000, 32'h0000_0080, "lbu");
    quick_load(3'b001, 32'h0000_0202, 32'h8001_7FFF, 32'hFFFF_8001, "lh");
    quick_load(3'b101, 32'h0000_0202, 32'h8001_7FFF, 32'h0000_8001, "lhu");

    // LW at 0x20, gnt only in C3, rvalid in C4
    mem_read_mem      = 1'b1;
    mem_load_type_mem = 3'b010;
    alu_result_mem    = 32'h0000_0020;
    wb_reg_file_mem   = 1'b1;
    memtoreg_mem      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) dmem.gnt = 1'b1;
      #1;
      chk($sformatf("lw_req_c%0d", c), {31'h0, dmem.req}, 32'd1);
      chk($sformatf("lw_stall_c%0d", c), {31'h0, mem_stall}, 32'd1);
      tick();
    end
    dmem.gnt = 1'b0;
    #1;
    chk("lw_wait_req", {31'h0, dmem.req}, 32'd0);
    chk("lw_wait_stall", {31'h0, mem_stall}, 32'd1);
    dmem.rvalid = 1'b1;
    dmem.rdata  = 32'hDEAD_BEEF;
    #1;
    chk("lw_done_stall", {31'h0, mem_stall}, 32'd0);
    tick();
    chk("lw_data", load_data_wb, 32'hDEAD_BEEF);
    chk("lw_wb", {31'h0, wb_reg_file_wb}, 32'd1);
    set_idle();

    // Misaligned LH at 0x101
    mem_read_mem      = 1'b1;
    mem_load_type_mem = 3'b001;
    alu_result_mem    = 32'h0000_0101;
    wb_reg_file_mem   = 1'b1;
    dmem.gnt          = 1'b1;
    #1;
    chk("mis_lh_req", {31'h0, dmem.req}, 32'd0);
    chk("mis_lh_stall", {31'h0, mem_stall}, 32'd0);
    tick();
    chk("mis_lh_err", {31'h0, mem_err_wb}, 32'd1);
    chk("mis_lh_wb", {31'h0, wb_reg_file_wb}, 32'd0);
    set_idle();
    tick();
    chk("err_pulse", {31'h0, mem_err_wb}, 32'd0);

    // Misaligned SW at 0x102
    mem_write_mem      = 1'b1;
    mem_store_type_mem = 2'b10;
    alu_result_mem     = 32'h0000_0102;
    wb_reg_file_mem    = 1'b1;
    #1;
    chk("mis_sw_req", {31'h0, dmem.req}, 32'd0);
    chk("mis_sw_stall", {31'h0, mem_stall}, 32'd0);
    tick();
    chk("mis_sw_err", {31'h0, mem_err_wb}, 32'd1);
    chk("mis_sw_wb", {31'h0, wb_reg_file_wb}, 32'd0);
    set_idle();
    tick();

    // Load never granted: stall for Timeout cycles then abort
    mem_read_mem      = 1'b1;
    mem_load_type_mem = 3'b010;
    alu_result_mem    = 32'h0000_0040;
    wb_reg_file_mem   = 1'b1;
    for (int c = 0; c < int'(Timeout); c++) begin
      #1;
      chk($sformatf("to_stall_c%0d", c), {31'h0, mem_stall}, 32'd1);
      tick();
    end
    chk("to_stall_drop", {31'h0, mem_stall}, 32'd0);
    tick();
    chk("to_err", {31'h0, mem_err_wb}, 32'd1);
    chk("to_wb", {31'h0, wb_reg_file_wb}, 32'd0);
    set_idle();
    tick();

    // Reset asserted while in WAIT
    mem_read_mem      = 1'b1;
    mem_load_type_mem = 3'b010;
    alu_result_mem    = 32'h0000_0080;
    rd_mem            = 5'd9;
    wb_reg_file_mem   = 1'b1;
    dmem.gnt          = 1'b1;
    tick();
    dmem.gnt = 1'b0;
    #1;
    chk("rw_wait_stall", {31'h0, mem_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rw_req", {31'h0, dmem.req}, 32'd0);
    chk("rw_alu_wb", alu_result_wb, 32'h0);
    chk("rw_rd_wb", {27'h0, rd_wb}, 32'd0);
    chk("rw_wb", {31'h0, wb_reg_file_wb}, 32'd0);
    set_idle();
    #1;
    rst_n = 1'b1;
    // Back in IDLE: a late rvalid must be ignored and an ALU op passes straight through
    dmem.rvalid     = 1'b1;
    alu_result_mem  = 32'h0000_0055;
    rd_mem          = 5'd3;
    wb_reg_file_mem = 1'b1;
    #1;
    chk("post_rst_stall", {31'h0, mem_stall}, 32'd0);
    tick();
    chk("post_rst_rd", {27'h0, rd_wb}, 32'd3);
    chk("post_rst_wb", {31'h0, wb_reg_file_wb}, 32'd1);
    set_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
